// File: rtl/ulab_operand_stage.sv
// rtl/ulab_operand_stage.sv - registered operand-B selector feeding a two-entry skid buffer
// Define ULAB_STAGE_SHL2_EN to add the shl2 input (selected source shifted left by 2).
module ulab_operand_stage #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 6,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        selector,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
`ifdef ULAB_STAGE_SHL2_EN
  input  logic                    shl2,
`endif
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [SEL_W:0] NUM_IN_V = NUM_IN[SEL_W:0];

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             sel_err_q, sel_err_d;

  logic [WIDTH-1:0] src_val;
  logic [WIDTH-1:0] push_val;
  logic             sel_oor;
  logic             push, pop;
  logic             load_main, main_from_skid, load_skid;

  // Out-of-range selectors match no source, so src_val stays zero for them.
  always_comb begin
    src_val = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if ({1'b0, selector} == k[SEL_W:0]) begin
        src_val = data_in[k*WIDTH +: WIDTH];
      end
    end
    sel_oor = ({1'b0, selector} >= NUM_IN_V);
  end

`ifdef ULAB_STAGE_SHL2_EN
  assign push_val = shl2 ? {src_val[WIDTH-3:0], 2'b00} : src_val;
`else
  assign push_val = src_val;
`endif

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          load_main = 1'b1;
          state_d   = S_HALF;
        end
      end
      S_HALF: begin
        if (push && pop) begin
          load_main = 1'b1;
        end else if (push) begin
          load_skid = 1'b1;
          state_d   = S_FULL;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          main_from_skid = 1'b1;
          state_d        = S_HALF;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Handshake outputs come from registered state only, never from in_valid/out_ready.
  always_comb begin
    out_valid = (state_q != S_EMPTY);
    in_ready  = (state_q != S_FULL);
  end

  always_comb begin
    main_d    = main_q;
    skid_d    = skid_q;
    sel_err_d = sel_err_q;
    if (load_main) begin
      main_d = push_val;
    end else if (main_from_skid) begin
      main_d = skid_q;
    end
    if (load_skid) begin
      skid_d = push_val;
    end
    if (push && sel_oor) begin
      sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q    <= '0;
      skid_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      main_q    <= main_d;
      skid_q    <= skid_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign data_out = main_q;
  assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_ulab_operand_stage.sv
// tb/tb_ulab_operand_stage.sv - scoreboard bench for ulab_operand_stage
// Reference model is a bounded queue of expected operands plus a sticky error flag.
module tb_ulab_operand_stage;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 6;
  localparam int SEL_W  = $clog2(NUM_IN);

  logic                    clk = 1'b0;
  logic                    reset;
  logic [SEL_W-1:0]        selector;
  logic [NUM_IN*WIDTH-1:0] data_in;
  logic                    shl2;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        data_out;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;

  always #5 clk = ~clk;

  ulab_operand_stage #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk       (clk),
    .reset     (reset),
    .selector  (selector),
    .data_in   (data_in),
`ifdef ULAB_STAGE_SHL2_EN
    .shl2      (shl2),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             sel_err_exp = 1'b0;
  logic [WIDTH-1:0] src[NUM_IN];
  bit               started = 1'b0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_val(input int s, input logic sh);
    logic [WIDTH-1:0] v;
    if (s >= NUM_IN) return '0;
    v = src[s];
`ifdef ULAB_STAGE_SHL2_EN
    if (sh) v = v << 2;
`else
    if (sh === 1'bz) v = '0;
`endif
    return v;
  endfunction

  // One cycle of stimulus; acceptance is decided from the registered in_ready.
  task automatic drive(input logic v, input int s, input logic sh, input logic r,
                       output logic acc);
    @(posedge clk); #1;
    in_valid  = v;
    selector  = s[SEL_W-1:0];
    shl2      = sh;
    out_ready = r;
    for (int k = 0; k < NUM_IN; k++) data_in[k*WIDTH +: WIDTH] = src[k];
    @(negedge clk); #1;
    acc = v && in_ready;
    if (acc) begin
      exp_q.push_back(ref_val(s, sh));
      if (s >= NUM_IN) sel_err_exp = 1'b1;
    end
  endtask

  task automatic do_reset(input logic v, input logic r);
    @(posedge clk); #1;
    reset     = 1'b1;
    in_valid  = v;
    out_ready = r;
    @(negedge clk); #1;
    exp_q.delete();
    sel_err_exp = 1'b0;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_data_out", data_out, '0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_sel_err", sel_err, 1'b0);
  endtask

  // Monitor: occupancy, sticky error, hold-under-stall and FIFO order.
  always @(negedge clk) begin
    if (started) begin
      check("in_ready_vs_model", in_ready, exp_q.size() < 2);
      check("out_valid_vs_model", out_valid, exp_q.size() > 0);
      check("sel_err_vs_model", sel_err, sel_err_exp);
      if (prev_stall) check("hold_under_stall", data_out, prev_data);
      if (out_valid && out_ready && !reset) begin
        if (exp_q.size() == 0) check("pop_unexpected", 1'b1, 1'b0);
        else check("data_out_order", data_out, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready && !reset;
      prev_data  = data_out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    logic acc;
    int   waits;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    selector  = '0;
    shl2      = 1'b0;
    data_in   = '0;
    for (int k = 0; k < NUM_IN; k++) src[k] = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("init_out_valid", out_valid, 1'b0);
    check("init_data_out", data_out, '0);
    check("init_in_ready", in_ready, 1'b1);
    check("init_sel_err", sel_err, 1'b0);
    started = 1'b1;

    // Single push, one-cycle latency, then empty again.
    src[2] = 32'h0000_00A5;
    drive(1'b1, 2, 1'b0, 1'b1, acc);
    drive(1'b0, 0, 1'b0, 1'b1, acc);
    check("single_valid", out_valid, 1'b1);
    check("single_data", data_out, 32'h0000_00A5);
    drive(1'b0, 0, 1'b0, 1'b1, acc);
    check("single_empty", out_valid, 1'b0);

    // Streaming at full rate.
    for (int k = 0; k < NUM_IN; k++) src[k] = k + 1;
    for (int k = 0; k < NUM_IN; k++) begin
      drive(1'b1, k, 1'b0, 1'b1, acc);
      check("stream_accept", acc, 1'b1);
    end
    repeat (3) drive(1'b0, 0, 1'b0, 1'b1, acc);

    // Backpressure: two accepted, third stalls while head holds.
    src[0] = 10; src[1] = 20; src[2] = 30;
    drive(1'b1, 0, 1'b0, 1'b0, acc);
    check("bp_accept_10", acc, 1'b1);
    drive(1'b1, 1, 1'b0, 1'b0, acc);
    check("bp_accept_20", acc, 1'b1);
    drive(1'b1, 2, 1'b0, 1'b0, acc);
    check("bp_reject_30", acc, 1'b0);
    check("bp_head_10", data_out, 32'd10);
    waits = 0;
    acc   = 1'b0;
    while (!acc && waits < 10) begin
      drive(1'b1, 2, 1'b0, 1'b1, acc);
      waits++;
    end
    check("bp_30_accepted", acc, 1'b1);
    repeat (4) drive(1'b0, 0, 1'b0, 1'b1, acc);

    // Out-of-range selector yields zero and a sticky error.
    drive(1'b1, 7, 1'b0, 1'b1, acc);
    drive(1'b1, 3, 1'b0, 1'b1, acc);
    check("oor_data_zero", data_out, '0);
    check("oor_sel_err", sel_err, 1'b1);
    drive(1'b1, 4, 1'b0, 1'b1, acc);
    drive(1'b0, 0, 1'b0, 1'b1, acc);
    check("oor_sticky", sel_err, 1'b1);

    // Reset while FULL with traffic pending.
    drive(1'b1, 1, 1'b0, 1'b0, acc);
    drive(1'b1, 2, 1'b0, 1'b0, acc);
    drive(1'b1, 7, 1'b0, 1'b0, acc);
    check("pre_reset_full", in_ready, 1'b0);
    do_reset(1'b1, 1'b1);

`ifdef ULAB_STAGE_SHL2_EN
    src[1] = 32'hC000_0003;
    drive(1'b1, 1, 1'b1, 1'b1, acc);
    drive(1'b1, 1, 1'b0, 1'b1, acc);
    check("shl2_on", data_out, 32'h0000_000C);
    drive(1'b0, 0, 1'b0, 1'b1, acc);
    check("shl2_off", data_out, 32'hC000_0003);
    drive(1'b0, 0, 1'b0, 1'b1, acc);
`endif

    // Randomized traffic with random backpressure and occasional bad selectors.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NUM_IN; k++) src[k] = $urandom;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0, acc);
      if (i == 200) do_reset($urandom_range(0, 1) == 1, 1'b1);
    end
    repeat (5) drive(1'b0, 0, 1'b0, 1'b1, acc);
    check("drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
